alu_mdu: RTL and testbench

//  Parametrised successor to the single-cycle ALU: integer execute unit for the RISC pipeline's EX stage.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_mdu_iter.sv | 147 ++++++++++++++
 rtl/alu_mdu.sv | 117 +++++++++++
 tb/tb_alu_mdu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_mdu shared package: opcodes, FSM states, mul/div decode.
// ALU_MDU_DIV_EN enables the divide/remainder opcodes.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_OR     = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_ADD    = 5'd3;
  localparam logic [4:0] ALU_SUB    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic is_mul(input logic [4:0] op);
    return (op == ALU_MUL) | (op == ALU_MULH) |
           (op == ALU_MULHSU) | (op == ALU_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == ALU_DIV) | (op == ALU_DIVU) |
           (op == ALU_REM) | (op == ALU_REMU);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return is_mul(op) | (DIV_EN & is_div(op));
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative mul/div engine: start,op,a,b -> done,res after WIDTH+1 cycles.
// Shift-add multiply; restoring divide only with ALU_MDU_DIV_EN.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             run_q;
  logic             sel_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
`ifdef ALU_MDU_DIV_EN
  logic             div_q;
  logic             zdiv_q;
`endif

  logic             op_div;
  logic             op_sel;
  logic             sa;
  logic             sb;
  logic             an;
  logic             bn;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic             ld_neg;
  logic [WIDTH-1:0] ld_b;
  logic [WIDTH-1:0] ld_lo;

  // Operand magnitudes; sign restored in the final cycle.
  always_comb begin
    op_div = DIV_EN & is_div(op_i);
    op_sel = (op_i == ALU_MULH) | (op_i == ALU_MULHSU) |
             (op_i == ALU_MULHU) | (op_i == ALU_REM) |
             (op_i == ALU_REMU);
    sa = (op_i == ALU_MUL) | (op_i == ALU_MULH) |
         (op_i == ALU_MULHSU) | (op_i == ALU_DIV) |
         (op_i == ALU_REM);
    sb = (op_i == ALU_MUL) | (op_i == ALU_MULH) |
         (op_i == ALU_DIV) | (op_i == ALU_REM);
    an = sa & a_i[WIDTH-1];
    bn = sb & b_i[WIDTH-1];
    ma = an ? -a_i : a_i;
    mb = bn ? -b_i : b_i;
    // Remainder follows the dividend's sign only.
    ld_neg = (op_div & op_sel) ? an : (an ^ bn);
    ld_b   = op_div ? mb : ma;
    ld_lo  = op_div ? ma : mb;
  end

  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] df;
`endif

  always_comb begin
    madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    {hi_d, lo_d} = {madd, lo_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    rs = {hi_q, lo_q[WIDTH-1]};
    ge = rs >= {1'b0, b_q};
    df = rs[WIDTH-1:0] - b_q;
    if (div_q) begin
      hi_d = ge ? df : rs[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      sel_q  <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef ALU_MDU_DIV_EN
      div_q  <= 1'b0;
      zdiv_q <= 1'b0;
`endif
    end else if (kill_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      sel_q  <= op_sel;
      neg_q  <= ld_neg;
      cnt_q  <= '0;
      b_q    <= ld_b;
      hi_q   <= '0;
      lo_q   <= ld_lo;
`ifdef ALU_MDU_DIV_EN
      div_q  <= op_div;
      zdiv_q <= (b_i == '0);
`endif
    end else if (run_q) begin
      if (cnt_q == LAST) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        hi_q  <= hi_d;
        lo_q  <= lo_d;
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;

  // Sign-fix cycle: cnt_q == LAST.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_f = neg_q ? -prod : prod;
    res_o  = sel_q ? prod_f[2*WIDTH-1:WIDTH] : prod_f[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      if (sel_q)       res_o = neg_q ? -hi_q : hi_q;
      else if (zdiv_q) res_o = '1;
      else             res_o = neg_q ? -lo_q : lo_q;
    end
`endif
  end

  assign done_o = run_q & (cnt_q == LAST);

endmodule

// File: rtl/alu_mdu.sv
// EX-stage integer unit: 1-cycle ALU ops plus iterative mul/div, valid/ready.
// Ports: clk rst_n flush in_valid/in_ready aluctrl in1 in2 out_valid/out_ready result zero busy; ALU_MDU_DIV_EN.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] aluctrl,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;

  // Codes beyond the 5-bit space fold onto an undefined opcode.
  logic [31:0] opw;
  logic [4:0]  op;
  assign opw = 32'(aluctrl);
  assign op  = (opw > 32'd31) ? 5'h1f : opw[4:0];

  logic md;
  logic accept;
  assign md       = is_muldiv(op);
  assign in_ready = !flush & ((state_q == ST_IDLE) |
                    ((state_q == ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] simple;
  assign shamt = in2[SW-1:0];

  always_comb begin
    simple = '0;
    unique case (1'b1)
      (op == ALU_AND):  simple = in1 & in2;
      (op == ALU_OR):   simple = in1 | in2;
      (op == ALU_XOR):  simple = in1 ^ in2;
      (op == ALU_ADD):  simple = in1 + in2;
      (op == ALU_SUB):  simple = in1 - in2;
      (op == ALU_SLL):  simple = in1 << shamt;
      (op == ALU_SRL):  simple = in1 >> shamt;
      (op == ALU_SRA):  simple = $unsigned($signed(in1) >>> shamt);
      (op == ALU_SLT):  simple = {{(WIDTH-1){1'b0}},
                                  $signed(in1) < $signed(in2)};
      (op == ALU_SLTU): simple = {{(WIDTH-1){1'b0}}, in1 < in2};
      default:          simple = '0;
    endcase
  end

  logic             it_done;
  logic [WIDTH-1:0] it_res;

  alu_mdu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .kill_i  (flush),
    .start_i (accept & md),
    .op_i    (op),
    .a_i     (in1),
    .b_i     (in2),
    .done_o  (it_done),
    .res_o   (it_res)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = md ? ST_CALC : ST_DONE;
      ST_CALC: if (it_done) state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_d = md ? ST_CALC : ST_DONE;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept & !md) result_d = simple;
    if ((state_q == ST_CALC) & it_done & !flush) result_d = it_res;
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: vector table + scoreboard queue, plus
// reset, backpressure and flush sequences.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int LMD = W + 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    aluctrl;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;

  alu_mdu #(
    .WIDTH  (W),
    .CTRL_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctrl   (aluctrl),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int         lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        nm;
  } exp_t;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic [W-1:0] exp_res = '0;
  int    exp_lat = 0;
  string exp_nm = "none";

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on output handshake.
  always @(negedge clk) begin
    exp_t it;
    cyc++;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h, expected no result",
                   result);
        end else begin
          it = exp_q.pop_front();
          chk({it.nm, "_res"}, 64'(result), 64'(it.res));
          chk({it.nm, "_zero"}, 64'(zero), 64'(it.res == '0));
          if (it.lat > 0)
            chk({it.nm, "_lat"}, 64'(cyc - it.acc), 64'(it.lat));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{exp_res, exp_lat, cyc, exp_nm});
    end
  end

  task automatic add(input string nm, input logic [4:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input string nm, input logic [4:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    aluctrl = op; in1 = a; in2 = b;
    exp_res = res; exp_lat = lat; exp_nm = nm;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept_timeout: got in_ready=0, expected 1", nm);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ov_seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluctrl = '0; in1 = '0; in2 = '0;

    add("add_zero", ALU_ADD, 32'd7, 32'hFFFFFFF9, 32'h0, 1);
    add("sub_neg1", ALU_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1);
    add("sra", ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1);
    add("and", ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    add("or", ALU_OR, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1);
    add("xor", ALU_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1);
    add("sll31", ALU_SLL, 32'd1, 32'd31, 32'h80000000, 1);
    add("srl31", ALU_SRL, 32'h80000000, 32'd31, 32'h1, 1);
    add("sll_mask", ALU_SLL, 32'd1, 32'd33, 32'h2, 1);
    add("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'h1, 1);
    add("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'h0, 1);
    add("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'h0, 1);
    add("undef", 5'd31, 32'd5, 32'd5, 32'h0, 1);
    add("mul", ALU_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, LMD);
    add("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LMD);
    add("mulh", ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, LMD);
    add("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, LMD);
    add("mul_by0", ALU_MUL, 32'h12345678, 32'd0, 32'h0, LMD);
    add("add_after_mul", ALU_ADD, 32'd100, 32'd23, 32'd123, 1);
`ifdef ALU_MDU_DIV_EN
    add("div_by0", ALU_DIV, 32'd7, 32'd0, 32'hFFFFFFFF, LMD);
    add("rem_by0", ALU_REM, 32'd7, 32'd0, 32'd7, LMD);
    add("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LMD);
    add("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, LMD);
    add("rem_neg", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LMD);
    add("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LMD);
    add("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, LMD);
    add("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, LMD);
    add("divu_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, LMD);
`else
    add("div_undef", ALU_DIV, 32'd7, 32'd2, 32'h0, 1);
    add("remu_undef", ALU_REMU, 32'd100, 32'd7, 32'h0, 1);
`endif

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i])
      send(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b,
           vecs[i].res, vecs[i].lat);
    drain();

    // Backpressure: hold result, then accept next op on release.
    out_ready = 1'b0;
    send("bp_first", ALU_ADD, 32'd2, 32'd3, 32'd5, 0);
    in_valid = 1'b1;
    aluctrl = ALU_ADD; in1 = 32'd10; in2 = 32'd20;
    exp_res = 32'd30; exp_lat = 1; exp_nm = "bp_next";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(result), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Flush in the middle of a multiply.
    send("flush_mul", ALU_MUL, 32'd9, 32'd9, 32'd81, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ov_seen |= out_valid;
    end
    chk("flush_no_result", 64'(ov_seen), 64'd0);
    @(posedge clk);
    #1;
    send("post_flush_add", ALU_ADD, 32'd1, 32'd1, 32'd2, 1);
    drain();

    // Asynchronous reset in the middle of a multiply.
    send("pre_rst_add", ALU_ADD, 32'd3, 32'd4, 32'd7, 1);
    drain();
    send("rst_mul", ALU_MUL, 32'd6, 32'd7, 32'd42, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_zero", 64'(zero), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    #8;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ov_seen |= out_valid;
    end
    chk("mrst_no_result", 64'(ov_seen), 64'd0);
    @(posedge clk);
    #1;
    send("post_rst_sub", ALU_SUB, 32'd10, 32'd4, 32'd6, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
